// File: rtl/hub75_pkg.sv
// Shared panel geometry, address widths and pixel-word layout for the HUB75 frame buffer path.
package hub75_pkg;

    localparam int DEF_COLS    = 64;
    localparam int DEF_ROWS    = 64;
    localparam int DEF_BPC     = 4;
    localparam int DEF_COL_W   = $clog2(DEF_COLS);
    localparam int DEF_ROW_W   = $clog2(DEF_ROWS);
    localparam int DEF_PAIR_W  = $clog2(DEF_ROWS / 2);
    localparam int DEF_PLANE_W = $clog2(DEF_BPC);

    // Channel position inside an {R,G,B} word; R sits in the MSBs.
    localparam int R_FIELD = 2;
    localparam int G_FIELD = 1;
    localparam int B_FIELD = 0;

    typedef enum logic [1:0] {
        FB_ACCEPT    = 2'd0,
        FB_SWAP_WAIT = 2'd1,
        FB_CLEAR     = 2'd2
    } fb_state_e;

    function automatic int field_ofs(input int field, input int bpc);
        return field * bpc;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Two-bank pixel RAM split into top/bottom halves so a single read address
// returns both pixels that the panel scans together.
module fb_ram #(
    parameter int DW = 12,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic          wr_bot,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_top_q,
    output logic [DW-1:0] rd_bot_q
);

    logic [DW-1:0] mem_top [2**AW];
    logic [DW-1:0] mem_bot [2**AW];

    // Top-half array: one write port, one registered read port.
    always_ff @(posedge clk) begin
        if (wr_en && !wr_bot) begin
            mem_top[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_top_q <= mem_top[rd_addr];
        end
    end

    // Bottom-half array: same shape, selected by the row MSB on writes.
    always_ff @(posedge clk) begin
        if (wr_en && wr_bot) begin
            mem_bot[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_bot_q <= mem_bot[rd_addr];
        end
    end

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered HUB75 pixel store: the host fills the back bank while the panel
// driver reads bit-planes of the front bank; swaps commit only on frame_done.
module frame_buffer
    import hub75_pkg::*;
#(
    parameter int  COLS = DEF_COLS,
    parameter int  ROWS = DEF_ROWS,
    parameter int  BPC  = DEF_BPC,
    localparam int XW   = $clog2(COLS),
    localparam int YW   = $clog2(ROWS),
    localparam int RW   = $clog2(ROWS / 2),
    localparam int PW   = $clog2(BPC),
    localparam int DW   = 3 * BPC
) (
    input  logic          clk_in,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  logic [DW-1:0] wr_rgb,
    input  logic          swap_req,
    input  logic          clr_req,
    output logic          busy,
    input  logic          frame_done,
    input  logic          rd_en,
    input  logic [RW-1:0] rd_row,
    input  logic [XW-1:0] rd_col,
    input  logic [PW-1:0] rd_plane,
    output logic [2:0]    rd_top,
    output logic [2:0]    rd_bot,
    output logic          front
);

    localparam int            AW      = 1 + RW + XW;
    localparam int            R_OFS   = field_ofs(R_FIELD, BPC);
    localparam int            G_OFS   = field_ofs(G_FIELD, BPC);
    localparam int            B_OFS   = field_ofs(B_FIELD, BPC);
    localparam logic [XW:0]   COL_LIM = (XW + 1)'(COLS);
    localparam logic [XW-1:0] X_LAST  = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(ROWS - 1);

    fb_state_e     state_q, state_d;
    logic          front_q, front_d;
    logic          wr_ready_q, wr_ready_d;
    logic          busy_q, busy_d;
    logic [XW-1:0] clr_x_q, clr_x_d;
    logic [YW-1:0] clr_y_q, clr_y_d;
    logic          rd_v1_q, rd_v1_d;
    logic [AW-1:0] rd_addr1_q, rd_addr1_d;
    logic [PW-1:0] rd_plane1_q, rd_plane1_d;
    logic          rd_v2_q, rd_v2_d;
    logic [PW-1:0] rd_plane2_q, rd_plane2_d;
    logic [2:0]    rd_top_q, rd_top_d;
    logic [2:0]    rd_bot_q, rd_bot_d;

    logic          ram_we;
    logic          ram_we_bot;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_wr_data;
    logic [DW-1:0] ram_top;
    logic [DW-1:0] ram_bot;
    logic          col_ok;

    // Planes outside 0..BPC-1 never match any index and therefore read as zero.
    function automatic logic [2:0] plane_bits(input logic [DW-1:0] w, input logic [PW-1:0] p);
        logic [2:0] bits;
        bits = 3'b000;
        for (int i = 0; i < BPC; i++) begin
            bits = (p == PW'(i)) ? {w[R_OFS + i], w[G_OFS + i], w[B_OFS + i]} : bits;
        end
        return bits;
    endfunction

    assign col_ok = ({1'b0, wr_x} < COL_LIM);

    // Control FSM: host writes, deferred swap, back-bank clear sweep.
    always_comb begin
        state_d     = state_q;
        front_d     = front_q;
        clr_x_d     = clr_x_q;
        clr_y_d     = clr_y_q;
        ram_we      = 1'b0;
        ram_we_bot  = wr_y[YW-1];
        ram_wr_addr = {~front_q, wr_y[RW-1:0], wr_x};
        ram_wr_data = wr_rgb;
        case (state_q)
            FB_ACCEPT: begin
                ram_we = wr_valid && col_ok;
                if (clr_req) begin
                    state_d = FB_CLEAR;
                    clr_x_d = {XW{1'b0}};
                    clr_y_d = {YW{1'b0}};
                end else if (swap_req) begin
                    if (frame_done) begin
                        front_d = ~front_q;
                    end else begin
                        state_d = FB_SWAP_WAIT;
                    end
                end else begin
                    state_d = FB_ACCEPT;
                end
            end
            FB_SWAP_WAIT: begin
                if (frame_done) begin
                    front_d = ~front_q;
                    state_d = FB_ACCEPT;
                end else begin
                    state_d = FB_SWAP_WAIT;
                end
            end
            FB_CLEAR: begin
                ram_we      = 1'b1;
                ram_we_bot  = clr_y_q[YW-1];
                ram_wr_addr = {~front_q, clr_y_q[RW-1:0], clr_x_q};
                ram_wr_data = {DW{1'b0}};
                if (clr_x_q == X_LAST) begin
                    clr_x_d = {XW{1'b0}};
                    if (clr_y_q == Y_LAST) begin
                        clr_y_d = {YW{1'b0}};
                        state_d = FB_ACCEPT;
                    end else begin
                        clr_y_d = clr_y_q + {{(YW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    clr_x_d = clr_x_q + {{(XW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = FB_ACCEPT;
            end
        endcase
        wr_ready_d = (state_d == FB_ACCEPT);
        busy_d     = (state_d != FB_ACCEPT);
    end

    // Read pipeline: capture request (bank fixed here), RAM read, then plane select.
    always_comb begin
        rd_v1_d = rd_en;
        if (rd_en) begin
            rd_addr1_d  = {front_q, rd_row, rd_col};
            rd_plane1_d = rd_plane;
        end else begin
            rd_addr1_d  = rd_addr1_q;
            rd_plane1_d = rd_plane1_q;
        end
        rd_v2_d = rd_v1_q;
        if (rd_v1_q) begin
            rd_plane2_d = rd_plane1_q;
        end else begin
            rd_plane2_d = rd_plane2_q;
        end
        if (rd_v2_q) begin
            rd_top_d = plane_bits(ram_top, rd_plane2_q);
            rd_bot_d = plane_bits(ram_bot, rd_plane2_q);
        end else begin
            rd_top_d = rd_top_q;
            rd_bot_d = rd_bot_q;
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q     <= FB_ACCEPT;
            front_q     <= 1'b0;
            wr_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            clr_x_q     <= {XW{1'b0}};
            clr_y_q     <= {YW{1'b0}};
            rd_v1_q     <= 1'b0;
            rd_addr1_q  <= {AW{1'b0}};
            rd_plane1_q <= {PW{1'b0}};
            rd_v2_q     <= 1'b0;
            rd_plane2_q <= {PW{1'b0}};
            rd_top_q    <= 3'b000;
            rd_bot_q    <= 3'b000;
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            wr_ready_q  <= wr_ready_d;
            busy_q      <= busy_d;
            clr_x_q     <= clr_x_d;
            clr_y_q     <= clr_y_d;
            rd_v1_q     <= rd_v1_d;
            rd_addr1_q  <= rd_addr1_d;
            rd_plane1_q <= rd_plane1_d;
            rd_v2_q     <= rd_v2_d;
            rd_plane2_q <= rd_plane2_d;
            rd_top_q    <= rd_top_d;
            rd_bot_q    <= rd_bot_d;
        end
    end

    fb_ram #(
        .DW (DW),
        .AW (AW)
    ) u_ram (
        .clk      (clk_in),
        .wr_en    (ram_we),
        .wr_bot   (ram_we_bot),
        .wr_addr  (ram_wr_addr),
        .wr_data  (ram_wr_data),
        .rd_en    (rd_v1_q),
        .rd_addr  (rd_addr1_q),
        .rd_top_q (ram_top),
        .rd_bot_q (ram_bot)
    );

    assign wr_ready = wr_ready_q;
    assign busy     = busy_q;
    assign front    = front_q;
    assign rd_top   = rd_top_q;
    assign rd_bot   = rd_bot_q;

endmodule
